// File: rtl/leg_cmd_sequencer_3l_pkg.sv
// Shared encodings for the 3-level leg command sequencer: levels, topology,
// commutation type and sequencer state.
package leg_cmd_sequencer_3l_pkg;

    localparam logic [1:0] LEV_O   = 2'd0;
    localparam logic [1:0] LEV_P   = 2'd1;
    localparam logic [1:0] LEV_N   = 2'd2;
    localparam logic [1:0] LEV_OFF = 2'd3;

    localparam logic [1:0] NOOUT = 2'd0;
    localparam logic [1:0] NPC   = 2'd1;
    localparam logic [1:0] NPP   = 2'd2;
    localparam logic [1:0] ANPC  = 2'd3;

    localparam logic [1:0] TYPE_I   = 2'd0;
    localparam logic [1:0] TYPE_IU  = 2'd1;
    localparam logic [1:0] TYPE_II  = 2'd2;
    localparam logic [1:0] TYPE_III = 2'd3;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RUN    = 3'd1,
        ST_BRIDGE = 3'd2,
        ST_CFG    = 3'd3,
        ST_FAULT  = 3'd4
    } seq_state_t;

    // P<->N swaps must pass through zero.
    function automatic logic is_opposite(input logic [1:0] cur, input logic [1:0] tgt);
        return ((cur == LEV_P) && (tgt == LEV_N)) || ((cur == LEV_N) && (tgt == LEV_P));
    endfunction

endpackage

// File: rtl/leg_cmd_sequencer_3l_dwell_timer.sv
// Minimum-hold timer: load wins over decrement, clear wins over load;
// decrements only on ce while nonzero. One-clk update latency, no backpressure.
module leg_cmd_sequencer_3l_dwell_timer #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          load,
    input  logic          clr,
    input  logic [DW-1:0] load_val,
    output logic          zero
);

    logic [DW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (ce && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/leg_cmd_sequencer_3l.sv
// Per-leg level sequencer: dwell-timed, zero-bridged v_lev stream plus decoder config.
// v_lev/config registered (1 clk); cfg_req is held pending until the leg is OFF and idle.
module leg_cmd_sequencer_3l
    import leg_cmd_sequencer_3l_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          en,
    input  logic [1:0]    req_lev,
    input  logic [DW-1:0] t_dwell,
    input  logic          fault,
    input  logic          fault_clr,
    input  logic          cfg_req,
    input  logic [1:0]    cfg_npc_type,
    input  logic [1:0]    cfg_comm_type,
    output logic [1:0]    v_lev,
    output logic [1:0]    npc_type,
    output logic [1:0]    comm_type_anpc,
    output logic          cfg_ack,
    output logic          busy,
    output logic          fault_act
);

    seq_state_t state_q, state_d;
    logic [1:0] v_lev_d, npc_d, comm_d;
    logic       ack_d;
    logic       en_q;
    logic       dw_load, dw_clr, dw_zero;
    logic       elig;
    logic       stop_req;

    leg_cmd_sequencer_3l_dwell_timer #(.DW(DW)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .load     (dw_load),
        .clr      (dw_clr),
        .load_val (t_dwell),
        .zero     (dw_zero)
    );

    assign elig     = ce && dw_zero;
    assign stop_req = !en || (req_lev == LEV_OFF);

    always_comb begin
        state_d = state_q;
        v_lev_d = v_lev;
        npc_d   = npc_type;
        comm_d  = comm_type_anpc;
        ack_d   = 1'b0;
        dw_load = 1'b0;
        dw_clr  = 1'b0;
        if (fault) begin
            state_d = ST_FAULT;
            v_lev_d = LEV_OFF;
            dw_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // A config request beats a run start that rises in the same cycle.
                    if (cfg_req && dw_zero && (!en || !en_q)) begin
                        state_d = ST_CFG;
                        npc_d   = cfg_npc_type;
                        comm_d  = cfg_comm_type;
                        ack_d   = 1'b1;
                        dw_load = 1'b1;
                    end else if (elig && en && (req_lev != LEV_OFF)) begin
                        state_d = ST_RUN;
                        v_lev_d = req_lev;
                        dw_load = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (elig) begin
                        if (stop_req) begin
                            state_d = ST_OFF;
                            v_lev_d = LEV_OFF;
                            dw_load = 1'b1;
                        end else if (is_opposite(v_lev, req_lev)) begin
                            state_d = ST_BRIDGE;
                            v_lev_d = LEV_O;
                            dw_load = 1'b1;
                        end else if (req_lev != v_lev) begin
                            v_lev_d = req_lev;
                            dw_load = 1'b1;
                        end
                    end
                end
                ST_BRIDGE: begin
                    if (elig) begin
                        if (stop_req) begin
                            state_d = ST_OFF;
                            v_lev_d = LEV_OFF;
                            dw_load = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            if (req_lev != LEV_O) begin
                                v_lev_d = req_lev;
                                dw_load = 1'b1;
                            end
                        end
                    end
                end
                ST_CFG: begin
                    if (dw_zero) begin
                        state_d = ST_OFF;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_OFF;
                        dw_load = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    v_lev_d = LEV_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_OFF;
            v_lev          <= LEV_OFF;
            npc_type       <= NOOUT;
            comm_type_anpc <= TYPE_I;
            cfg_ack        <= 1'b0;
            en_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            v_lev          <= v_lev_d;
            npc_type       <= npc_d;
            comm_type_anpc <= comm_d;
            cfg_ack        <= ack_d;
            en_q           <= en;
        end
    end

    assign busy      = !dw_zero || (state_q == ST_BRIDGE) || (state_q == ST_CFG);
    assign fault_act = (state_q == ST_FAULT);

endmodule

// File: tb/tb_leg_cmd_sequencer_3l.sv
// Directed bench for leg_cmd_sequencer_3l; inputs change and outputs are sampled on negedge.
module tb_leg_cmd_sequencer_3l;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce, en, fault, fault_clr, cfg_req;
    logic [1:0] req_lev, cfg_npc_type, cfg_comm_type;
    logic [7:0] t_dwell;
    logic [1:0] v_lev, npc_type, comm_type_anpc;
    logic       cfg_ack, busy, fault_act;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    leg_cmd_sequencer_3l #(.DW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .en             (en),
        .req_lev        (req_lev),
        .t_dwell        (t_dwell),
        .fault          (fault),
        .fault_clr      (fault_clr),
        .cfg_req        (cfg_req),
        .cfg_npc_type   (cfg_npc_type),
        .cfg_comm_type  (cfg_comm_type),
        .v_lev          (v_lev),
        .npc_type       (npc_type),
        .comm_type_anpc (comm_type_anpc),
        .cfg_ack        (cfg_ack),
        .busy           (busy),
        .fault_act      (fault_act)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, ".v_lev"}, int'(v_lev), 3);
        check_val({tag, ".npc"}, int'(npc_type), 0);
        check_val({tag, ".comm"}, int'(comm_type_anpc), 0);
        check_val({tag, ".ack"}, int'(cfg_ack), 0);
        check_val({tag, ".busy"}, int'(busy), 0);
        check_val({tag, ".fault_act"}, int'(fault_act), 0);
    endtask

    initial begin
        int chg [3];
        int nchg;
        int acks;
        logic [1:0] prev;

        rst = 1'b1; ce = 1'b0; en = 1'b0; fault = 1'b0; fault_clr = 1'b0; cfg_req = 1'b0;
        req_lev = 2'd3; cfg_npc_type = 2'd0; cfg_comm_type = 2'd0; t_dwell = 8'd0;
        step(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // Dwell hold: P visible one clk later, O refused for 3 clks, appears at 4
        ce = 1'b1; t_dwell = 8'd3; en = 1'b1; req_lev = 2'd1;
        step(1);
        check_val("start_p", int'(v_lev), 1);
        req_lev = 2'd0;
        step(1);
        check_val("hold1", int'(v_lev), 1);
        check_val("hold1_busy", int'(busy), 1);
        step(1);
        check_val("hold2", int'(v_lev), 1);
        step(1);
        check_val("hold3", int'(v_lev), 1);
        step(1);
        check_val("to_o", int'(v_lev), 0);

        // O -> P direct, then P -> N bridged through O for 3 clks
        req_lev = 2'd1; t_dwell = 8'd2;
        step(4);
        check_val("o_to_p", int'(v_lev), 1);
        req_lev = 2'd2;
        step(2);
        check_val("pn_hold", int'(v_lev), 1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_val($sformatf("bridge_o%0d", i), int'(v_lev), 0);
            check_val($sformatf("bridge_busy%0d", i), int'(busy), 1);
        end
        step(1);
        check_val("bridge_n", int'(v_lev), 2);

        // Fault at N; clear ignored while fault high; exit holds OFF for t_dwell
        fault = 1'b1;
        step(1);
        check_val("fault_v", int'(v_lev), 3);
        check_val("fault_act", int'(fault_act), 1);
        fault_clr = 1'b1;
        step(1);
        check_val("clr_ignored", int'(fault_act), 1);
        fault = 1'b0; t_dwell = 8'd3; req_lev = 2'd1;
        step(1);
        fault_clr = 1'b0;
        check_val("fault_cleared", int'(fault_act), 0);
        check_val("fault_exit_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_val($sformatf("post_fault_off%0d", i), int'(v_lev), 3);
        end
        step(1);
        check_val("post_fault_run", int'(v_lev), 1);

        // ce every 4th clk with t_dwell=1: changes spaced 8 clks
        step(3);
        t_dwell = 8'd1; req_lev = 2'd0;
        nchg = 0; prev = v_lev;
        for (int k = 0; k < 20; k++) begin
            ce = (k % 4 == 0);
            step(1);
            if (v_lev != prev && nchg < 3) begin
                chg[nchg] = k;
                nchg++;
                req_lev = (v_lev == 2'd0) ? 2'd1 : 2'd0;
            end
            prev = v_lev;
        end
        check_val("ce_nchg", nchg, 3);
        check_val("ce_gap1", chg[1] - chg[0], 8);
        check_val("ce_gap2", chg[2] - chg[1], 8);

        // Config from OFF
        ce = 1'b1; en = 1'b0; req_lev = 2'd3;
        step(4);
        check_val("off_v", int'(v_lev), 3);
        check_val("off_busy", int'(busy), 0);
        cfg_req = 1'b1; cfg_npc_type = 2'd3; cfg_comm_type = 2'd2; t_dwell = 8'd2;
        step(1);
        cfg_req = 1'b0;
        check_val("cfg_ack", int'(cfg_ack), 1);
        check_val("cfg_npc", int'(npc_type), 3);
        check_val("cfg_comm", int'(comm_type_anpc), 2);
        check_val("cfg_v", int'(v_lev), 3);
        step(1);
        check_val("cfg_ack_once", int'(cfg_ack), 0);
        check_val("cfg_busy", int'(busy), 1);
        step(3);
        check_val("cfg_done_busy", int'(busy), 0);

        // Config pending while en=1, acked once en drops
        en = 1'b1;
        step(2);
        cfg_req = 1'b1; cfg_npc_type = 2'd1; cfg_comm_type = 2'd1;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            acks += int'(cfg_ack);
        end
        check_val("pend_no_ack", acks, 0);
        check_val("pend_npc", int'(npc_type), 3);
        en = 1'b0;
        step(1);
        cfg_req = 1'b0;
        check_val("pend_ack", int'(cfg_ack), 1);
        check_val("pend_npc_new", int'(npc_type), 1);
        check_val("pend_comm_new", int'(comm_type_anpc), 1);
        step(4);

        // en rising together with cfg_req: config first, then run
        en = 1'b1; req_lev = 2'd1; cfg_req = 1'b1; cfg_npc_type = 2'd2; cfg_comm_type = 2'd3;
        step(1);
        cfg_req = 1'b0;
        check_val("sim_ack", int'(cfg_ack), 1);
        check_val("sim_npc", int'(npc_type), 2);
        check_val("sim_v", int'(v_lev), 3);
        step(3);
        check_val("sim_still_off", int'(v_lev), 3);
        step(1);
        check_val("sim_run", int'(v_lev), 1);

        // Async reset mid-bridge
        req_lev = 2'd2;
        step(3);
        check_val("pre_rst_bridge", int'(v_lev), 0);
        check_val("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        step(1);
        rst = 1'b0;
        step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leg_cmd_sequencer_3l.md
# leg_cmd_sequencer_3l

Per-leg command sequencer sitting between the modulator and the 3-level leg decoder. It turns a requested output level into a legal, dwell-timed `v_lev` stream: every level is held for a minimum time, and P↔N swaps always bridge through zero. It also owns the decoder's topology and commutation configuration (`npc_type`, `comm_type_anpc`), applying changes only while the leg is safely OFF. A fault input forces the leg OFF immediately.

## Interface
Parameters:
- `DW`, 8: width of the dwell timer and of `t_dwell`.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  timebase tick; all dwell counting and level stepping advance only on `ce`=1.
- `en`  in  1  run enable; 0 drives the leg to OFF.
- `req_lev`  in  2  requested level: 0=O (zero), 1=P, 2=N, 3=OFF.
- `t_dwell`  in  DW  minimum hold per level, in `ce` ticks; sampled when a level change is issued.
- `fault`  in  1  level-sensitive fault; not gated by `ce`.
- `fault_clr`  in  1  single-cycle pulse; clears a latched fault.
- `cfg_req`  in  1  configuration request; held until `cfg_ack`.
- `cfg_npc_type`  in  2  requested topology: 0=NOOUT, 1=NPC, 2=NPP, 3=ANPC.
- `cfg_comm_type`  in  2  requested ANPC commutation type: 0=I, 1=IU, 2=II, 3=III.
- `v_lev`  out  2  level command to the decoder (same encoding as `req_lev`).
- `npc_type`  out  2  registered topology select to the decoder.
- `comm_type_anpc`  out  2  registered commutation type to the decoder.
- `cfg_ack`  out  1  one-cycle pulse when the configuration is applied.
- `busy`  out  1  1 while the dwell counter ≠ 0 or state is BRIDGE/CFG.
- `fault_act`  out  1  1 while a fault is latched.

## Operation
- Reset values: `v_lev`=3 (OFF), `npc_type`=0, `comm_type_anpc`=0, `cfg_ack`=0, `fault_act`=0, `busy`=0, dwell=0, state OFF.
- States: OFF, RUN, BRIDGE, CFG, FAULT.
- Dwell: loaded with `t_dwell` on every `v_lev` change. It decrements on each `ce` while nonzero. A new change is permitted only on a `ce` cycle with dwell=0.
- OFF: on an eligible `ce` with `en`=1 and `req_lev`≠3, set `v_lev`=`req_lev` and go to RUN. Direct OFF→P or OFF→N is allowed.
- RUN, eligible `ce`:
  - `en`=0 or `req_lev`=3 → `v_lev`=OFF, go to OFF.
  - Target is the opposite polarity of the current level (P↔N) → `v_lev`=O, go to BRIDGE.
  - Target differs otherwise → set `v_lev`=target directly.
  - Target equals current level → no change, and dwell is not reloaded.
- BRIDGE, eligible `ce`:
  - `en`=0 or `req_lev`=3 → OFF.
  - `req_lev` is P or N → issue it, go to RUN.
  - `req_lev`=O → go to RUN with `v_lev` left at O.
- CFG: entered from OFF when `cfg_req`=1, `en`=0 and dwell=0. Entry does not wait for `ce`.
  - On entry: latch `cfg_npc_type` and `cfg_comm_type` into the outputs, pulse `cfg_ack` for one clk, load dwell with `t_dwell`.
  - `v_lev` stays OFF throughout.
  - Return to OFF when dwell reaches 0.
- `cfg_req` while `en`=1 or while not in OFF stays pending. It is not acknowledged and does not affect `v_lev`.
- Simultaneous `cfg_req` and `en` rising while in OFF: configuration wins and CFG is entered; the run starts after CFG completes.
- FAULT (from any state, not gated by `ce`): `fault`=1 → next clk `v_lev`=OFF, `fault_act`=1, state FAULT, dwell cleared.
  - Exit requires `fault`=0 and `fault_clr`=1 in the same cycle. On exit go to OFF with dwell loaded from `t_dwell`.
  - `fault_clr` while `fault`=1 is ignored.
  - Fault has priority over every other event, including a `cfg_ack` cycle.
- Asynchronous `rst` mid-operation returns all outputs to reset values immediately. Any pending `cfg_req` is dropped and must be re-presented.

## Timing
- `v_lev` is registered. A change becomes visible one clk after the `ce` cycle that enables it.
- With `ce`=1 continuously and `t_dwell`=k, consecutive `v_lev` changes are spaced exactly k+1 clks. With `t_dwell`=0 they are spaced 1 clk.
- A P→N request costs two dwell periods: P→O, then O→N.
- `cfg_ack` occurs 1 clk after CFG is entered. `npc_type` and `comm_type_anpc` update on the same edge as `cfg_ack`.
- Fault→OFF latency is 1 clk regardless of `ce`.

## Structure
- Shared package holds:
  - level encodings `LEV_O`, `LEV_P`, `LEV_N`, `LEV_OFF`;
  - topology constants `NOOUT`, `NPC`, `NPP`, `ANPC`;
  - commutation constants `TYPE_I`, `TYPE_IU`, `TYPE_II`, `TYPE_III`;
  - the state encoding.
- One natural sub-module: `dwell_timer` (load, `ce`-gated decrement, zero flag, DW wide).

## Test plan
- `ce`=1, `t_dwell`=3, `en`=1, `req_lev`=P from OFF → `v_lev`=1 one clk later; change to `req_lev`=O is refused for 3 clks, then `v_lev`=0 exactly 4 clks after the P edge.
- In RUN at P, `t_dwell`=2, `req_lev`=N → `v_lev` sequence P, O (held 3 clks), N; `busy`=1 throughout the bridge.
- `ce` pulsed every 4th clk, `t_dwell`=1 → level changes spaced 8 clks.
- `en`=0, `cfg_req`=1 with type 3 / comm 2 → `cfg_ack` pulses once, `npc_type`=3, `comm_type_anpc`=2, `v_lev` stays 3.
- Same `cfg_req` with `en`=1 → no ack; ack follows once `en`=0 and dwell expires.
- `fault`=1 while at N → `v_lev`=3 and `fault_act`=1 next clk. `fault_clr` with `fault`=1 is ignored; with `fault`=0 it clears, and no run starts before `t_dwell` expires.
- Assert `rst` mid-bridge → all outputs return to reset values immediately.
